// File: rtl/cache_pkg.sv
// Shared widths and constants for the set-associative cache array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: address field width helpers, tag-control bit positions, I-cache defaults.
package cache_pkg;

  // Tag-control bit positions inside each tag entry.
  localparam int VALID_BIT = 0;
  localparam int DIRTY_BIT = 1;

  // Defaults used when the array is instantiated as the fetch-stage I-cache.
  localparam int ICACHE_BLOCK_SIZE_BITS   = 64;
  localparam int ICACHE_NUM_SETS          = 64;
  localparam int ICACHE_NUM_WAYS          = 2;
  localparam int ICACHE_NUM_TAG_CTRL_BITS = 1;
  localparam int ICACHE_WRITE_SIZE_BITS   = 64;

  // Byte-offset bits within one line.
  function automatic int off_w(input int block_bits);
    return $clog2(block_bits / 8);
  endfunction

  // Set-index bits.
  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag bits: whatever remains of the 32-bit address.
  function automatic int tag_w(input int block_bits, input int num_sets);
    return 32 - off_w(block_bits) - idx_w(num_sets);
  endfunction

  // Write-slot select width; a single-slot line still gets a 1-bit select.
  function automatic int slot_w(input int block_bits, input int write_bits);
    return (block_bits / write_bits > 1) ? $clog2(block_bits / write_bits) : 1;
  endfunction

  // Way-number width (victim pointer), 1-bit minimum.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Lookup/write bus between fetch/LSU logic and the cache array.
// Latency: read outputs are combinational from addr; writes commit on the clk rising edge.
// Backpressure: none; every write with we_aL low is accepted that edge.
// master: drives addr/write_data/d_cache_is_ST/we_aL, receives cache_hit/selected_data_way.
// slave : the cache array.
interface set_assoc_cache_if #(
  parameter int BLOCK_SIZE_BITS = 64,
  parameter int WRITE_SIZE_BITS = 64
);
  logic [31:0]                addr;
  logic [WRITE_SIZE_BITS-1:0] write_data;
  logic                       d_cache_is_ST;
  logic                       we_aL;
  logic [BLOCK_SIZE_BITS-1:0] selected_data_way;
  logic                       cache_hit;

  modport master (
    output addr, write_data, d_cache_is_ST, we_aL,
    input  selected_data_way, cache_hit
  );

  modport slave (
    input  addr, write_data, d_cache_is_ST, we_aL,
    output selected_data_way, cache_hit
  );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: tag, control bits and data line for every set, plus tag match.
// Latency: match/valid/data combinational from index/tag; writes commit on the clk rising edge.
// Backpressure: none; write strobes are acted on the edge they are high.
// Ports: index/tag/slot address the entry; data_we writes one slot, alloc_we installs
// the tag and marks the entry valid+clean, dirty_we sets the dirty bit (if present).
module cache_way
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE_BITS   = 64,
  parameter int NUM_SETS          = 64,
  parameter int NUM_TAG_CTRL_BITS = 1,
  parameter int WRITE_SIZE_BITS   = 64,
  localparam int IDX_W  = idx_w(NUM_SETS),
  localparam int TAG_W  = tag_w(BLOCK_SIZE_BITS, NUM_SETS),
  localparam int SLOT_W = slot_w(BLOCK_SIZE_BITS, WRITE_SIZE_BITS)
) (
  input  logic                       clk,
  input  logic                       rst_aL,
  input  logic [IDX_W-1:0]           index,
  input  logic [TAG_W-1:0]           tag,
  input  logic [SLOT_W-1:0]          slot,
  input  logic [WRITE_SIZE_BITS-1:0] wdata,
  input  logic                       data_we,
  input  logic                       alloc_we,
  input  logic                       dirty_we,
  output logic                       match,
  output logic                       valid,
  output logic [BLOCK_SIZE_BITS-1:0] data
);

  localparam int CTRL_W = NUM_TAG_CTRL_BITS;
  localparam logic [CTRL_W-1:0] VALID_MASK = CTRL_W'(1 << VALID_BIT);
  // Single-bit control entries carry no dirty bit, so the mask collapses to zero.
  localparam logic [CTRL_W-1:0] DIRTY_MASK = (CTRL_W > 1) ? CTRL_W'(1 << DIRTY_BIT) : '0;

  logic [TAG_W-1:0]           tag_q  [NUM_SETS];
  logic [CTRL_W-1:0]          ctrl_q [NUM_SETS];
  logic [BLOCK_SIZE_BITS-1:0] data_q [NUM_SETS];

  // Control bits are the only reset state; stale tags/data are masked by valid=0.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int s = 0; s < NUM_SETS; s++) ctrl_q[s] <= '0;
    end else if (alloc_we) begin
      ctrl_q[index] <= VALID_MASK;
    end else if (dirty_we) begin
      ctrl_q[index] <= ctrl_q[index] | DIRTY_MASK;
    end
  end

  // rst_aL gates the arrays so a write coinciding with reset has no effect.
  always_ff @(posedge clk) begin
    if (rst_aL && data_we)
      data_q[index][int'(slot)*WRITE_SIZE_BITS +: WRITE_SIZE_BITS] <= wdata;
    if (rst_aL && alloc_we)
      tag_q[index] <= tag;
  end

  assign valid = ctrl_q[index][VALID_BIT];
  assign match = valid && (tag_q[index] == tag);
  assign data  = data_q[index];

  // Dirty bit is kept for the surrounding LSU's write-back logic, not read here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_q[index];

endmodule

// File: rtl/set_assoc_cache.sv
// Set-associative cache array: combinational tag lookup, synchronous fill/store writes.
// Latency: hit/data 0 cycles from addr; writes visible right after the clk rising edge.
// Backpressure: none; miss handling belongs to the surrounding fetch/LSU logic.
// Ports: clk, rst_aL (async active-low), bus (slave: addr, write_data, d_cache_is_ST,
// we_aL in; cache_hit, selected_data_way out).
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE_BITS   = ICACHE_BLOCK_SIZE_BITS,
  parameter int NUM_SETS          = ICACHE_NUM_SETS,
  parameter int NUM_WAYS          = ICACHE_NUM_WAYS,
  parameter int NUM_TAG_CTRL_BITS = ICACHE_NUM_TAG_CTRL_BITS,
  parameter int WRITE_SIZE_BITS   = ICACHE_WRITE_SIZE_BITS
) (
  input  logic           clk,
  input  logic           rst_aL,
  set_assoc_cache_if.slave bus
);

  localparam int OFF_W    = off_w(BLOCK_SIZE_BITS);
  localparam int IDX_W    = idx_w(NUM_SETS);
  localparam int TAG_W    = tag_w(BLOCK_SIZE_BITS, NUM_SETS);
  localparam int SLOT_W   = slot_w(BLOCK_SIZE_BITS, WRITE_SIZE_BITS);
  localparam int WAY_W    = way_w(NUM_WAYS);
  localparam int BYTE_LOG = $clog2(WRITE_SIZE_BITS / 8);

  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [SLOT_W-1:0] slot;

  assign index = bus.addr[OFF_W +: IDX_W];
  assign tag   = bus.addr[31 -: TAG_W];
  // Bytes below the write granularity drop out; with a one-slot line this is 0.
  assign slot  = SLOT_W'(bus.addr[OFF_W-1:0] >> BYTE_LOG);

  logic unused_addr;
  assign unused_addr = ^bus.addr[OFF_W-1:0];

  logic [NUM_WAYS-1:0]        match;
  logic [NUM_WAYS-1:0]        valid;
  logic [BLOCK_SIZE_BITS-1:0] way_data [NUM_WAYS];
  logic [NUM_WAYS-1:0]        data_we, alloc_we, dirty_we;

  logic hit, wr, fill_miss;
  assign hit       = |match;
  assign wr        = ~bus.we_aL;
  assign fill_miss = wr && !bus.d_cache_is_ST && !hit;

  // Victim choice: lowest invalid way wins; only a full set consults the pointer.
  logic [WAY_W-1:0] vp_q [NUM_SETS];
  logic [WAY_W-1:0] alloc_way;
  logic             any_invalid;

  always_comb begin
    any_invalid = 1'b0;
    alloc_way   = vp_q[index];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        any_invalid = 1'b1;
        alloc_way   = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int s = 0; s < NUM_SETS; s++) vp_q[s] <= '0;
    end else if (fill_miss && !any_invalid) begin
      vp_q[index] <= (vp_q[index] == WAY_W'(NUM_WAYS - 1)) ? '0 : vp_q[index] + WAY_W'(1);
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    // Hit (fill or store) rewrites the matching way; a fill miss writes the victim.
    assign alloc_we[w] = fill_miss && (alloc_way == WAY_W'(w));
    assign data_we[w]  = (wr && match[w]) || alloc_we[w];
    assign dirty_we[w] = wr && bus.d_cache_is_ST && match[w];

    cache_way #(
      .BLOCK_SIZE_BITS  (BLOCK_SIZE_BITS),
      .NUM_SETS         (NUM_SETS),
      .NUM_TAG_CTRL_BITS(NUM_TAG_CTRL_BITS),
      .WRITE_SIZE_BITS  (WRITE_SIZE_BITS)
    ) u_way (
      .clk     (clk),
      .rst_aL  (rst_aL),
      .index   (index),
      .tag     (tag),
      .slot    (slot),
      .wdata   (bus.write_data),
      .data_we (data_we[w]),
      .alloc_we(alloc_we[w]),
      .dirty_we(dirty_we[w]),
      .match   (match[w]),
      .valid   (valid[w]),
      .data    (way_data[w])
    );
  end

  // At most one way matches, so an AND-OR mux is sufficient and yields 0 on a miss.
  always_comb begin
    bus.selected_data_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (match[w]) bus.selected_data_way = bus.selected_data_way | way_data[w];
    end
  end

  assign bus.cache_hit = hit;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with default parameters (64b line, 64 sets, 2 ways).
module tb_set_assoc_cache;

  logic clk;
  logic rst_aL;
  int   tests;
  int   fails;

  set_assoc_cache_if #(.BLOCK_SIZE_BITS(64), .WRITE_SIZE_BITS(64)) cif ();

  set_assoc_cache dut (
    .clk   (clk),
    .rst_aL(rst_aL),
    .bus   (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] A = 64'h0000_0000_7654_3210;
  localparam logic [63:0] B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C = 64'hCAFE_F00D_0000_0003;
  localparam logic [63:0] D = 64'h0000_0000_0000_0D0D;
  localparam logic [63:0] E = 64'hEEEE_0000_EEEE_0000;
  localparam logic [63:0] F = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] S = 64'h0000_0000_DEAD_BEEF;

  // Compare the current outputs (no address change, no clock wait).
  task automatic cmp(input string tag, input logic exp_hit, input logic [63:0] exp_data);
    tests++;
    assert (cif.cache_hit === exp_hit)
      else begin
        fails++;
        $error("FAIL %s hit: observed %0b expected %0b", tag, cif.cache_hit, exp_hit);
      end
    tests++;
    assert (cif.selected_data_way === exp_data)
      else begin
        fails++;
        $error("FAIL %s data: observed %h expected %h", tag, cif.selected_data_way, exp_data);
      end
  endtask

  // Look up an address mid-cycle, away from the rising edge.
  task automatic check(input string tag, input logic [31:0] a, input logic exp_hit,
                       input logic [63:0] exp_data);
    @(negedge clk);
    cif.addr = a;
    #1;
    cmp(tag, exp_hit, exp_data);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic st);
    @(negedge clk);
    cif.addr          = a;
    cif.write_data    = d;
    cif.d_cache_is_ST = st;
    cif.we_aL         = 1'b0;
    @(posedge clk);
    #1;
    cif.we_aL         = 1'b1;
    cif.d_cache_is_ST = 1'b0;
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    rst_aL            = 1'b0;
    cif.addr          = 32'h0;
    cif.write_data    = '0;
    cif.d_cache_is_ST = 1'b0;
    cif.we_aL         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_aL = 1'b1;

    // Reset state: everything misses.
    check("reset_miss", 32'h0000_0004, 1'b0, 64'h0);

    // Fill 0x004; outputs still show the miss before the edge, then the new line.
    @(negedge clk);
    cif.addr          = 32'h0000_0004;
    cif.write_data    = A;
    cif.d_cache_is_ST = 1'b0;
    cif.we_aL         = 1'b0;
    #1;
    cmp("pre_edge_miss", 1'b0, 64'h0);
    @(posedge clk);
    #1;
    cif.we_aL = 1'b1;
    cmp("fill_hit", 1'b1, A);

    // Misaligned addresses inside the same line.
    check("misalign_0", 32'h0000_0000, 1'b1, A);
    check("misalign_7", 32'h0000_0007, 1'b1, A);

    // we_aL high: no change over several cycles.
    @(negedge clk);
    cif.addr       = 32'h0000_0004;
    cif.write_data = 64'h11;
    repeat (3) @(posedge clk);
    check("no_we_hold", 32'h0000_0004, 1'b1, A);

    // Store hit updates the block; store miss does not allocate.
    do_write(32'h0000_0004, S, 1'b1);
    check("store_hit", 32'h0000_0004, 1'b1, S);
    do_write(32'h0000_0804, S, 1'b1);
    check("store_miss_noalloc", 32'h0000_0804, 1'b0, 64'h0);
    check("store_miss_other", 32'h0000_0004, 1'b1, S);

    // Set 0: 0x004 in way0, 0x204 to way1, then 0x404 evicts way0 (pointer 0 -> 1).
    do_write(32'h0000_0204, B, 1'b0);
    do_write(32'h0000_0404, C, 1'b0);
    check("evict_004", 32'h0000_0004, 1'b0, 64'h0);
    check("keep_204", 32'h0000_0204, 1'b1, B);
    check("new_404", 32'h0000_0404, 1'b1, C);

    // Fill hit overwrites in place without moving the pointer.
    do_write(32'h0000_0204, D, 1'b0);
    check("fill_hit_overwrite", 32'h0000_0204, 1'b1, D);

    // Pointer is at way1 now, so the next miss evicts 0x204.
    do_write(32'h0000_0004, E, 1'b0);
    check("rr_evict_204", 32'h0000_0204, 1'b0, 64'h0);
    check("rr_keep_404", 32'h0000_0404, 1'b1, C);
    check("rr_new_004", 32'h0000_0004, 1'b1, E);

    // Different set is independent.
    do_write(32'h0000_0008, F, 1'b0);
    check("set1_fill", 32'h0000_0008, 1'b1, F);
    check("set0_intact", 32'h0000_0404, 1'b1, C);

    // Async reset mid-cycle: hits vanish with no clock edge.
    @(negedge clk);
    cif.addr = 32'h0000_0404;
    #1;
    cmp("pre_reset_hit", 1'b1, C);
    #1;
    rst_aL = 1'b0;
    #1;
    cmp("async_reset_miss", 1'b0, 64'h0);

    // Reset wins over a write held during reset.
    cif.addr       = 32'h0000_0010;
    cif.write_data = B;
    cif.we_aL      = 1'b0;
    @(posedge clk);
    #1;
    cif.we_aL = 1'b1;
    cmp("reset_beats_write", 1'b0, 64'h0);
    @(negedge clk);
    rst_aL = 1'b1;
    check("post_reset_008", 32'h0000_0008, 1'b0, 64'h0);
    check("post_reset_010", 32'h0000_0010, 1'b0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
